pipe_reg_chain: RTL and testbench
=================================

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 18, data width in bits (legal range 1..48).
REQ-002 Parameter MAX_DEPTH, default 4, number of physical pipeline stages (legal range 1..16).
REQ-003 Derived width LSW = ceil(log2(MAX_DEPTH+1)), width of LAT_SEL.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 CE  input  1  clock enable for all stages and the fill counter.
REQ-007 LAT_SEL  input  LSW  runtime latency select, 0..MAX_DEPTH.
REQ-008 D  input  WIDTH  data in.
REQ-009 Q  output  WIDTH  data out, tapped at the selected latency.
REQ-010 FILLED  output  1  high when the selected pipe holds LAT_SEL entries captured since the last reset or latency change.
REQ-011 VLD_IN  input  1  valid tag for D (present only with PIPE_VALID_EN).
REQ-012 VLD_OUT  output  1  valid tag aligned with Q (present only with PIPE_VALID_EN).

Function
REQ-013 Stages S1..S_MAX_DEPTH SHALL form a shift chain: on a CE=1 edge, S1<=D and Sk<=S(k-1); on CE=0 all stages hold.
REQ-014 Effective latency L SHALL be min(LAT_SEL, MAX_DEPTH); out-of-range LAT_SEL clamps to MAX_DEPTH.
REQ-015 L=0: Q SHALL equal D combinationally (bypass, zero latency).
REQ-016 L=k>0: Q SHALL equal S_k, i.e. D delayed by exactly k CE-qualified edges.
REQ-017 Stages beyond L SHALL keep shifting; a latency change SHALL NOT clear stage contents.
REQ-018 Register lat_q SHALL capture L every edge (independent of CE).
REQ-019 Fill counter cnt (width LSW): if L != lat_q it SHALL load 0; else if CE=1 and cnt<L it SHALL increment; otherwise hold (saturate at L).
REQ-020 FILLED SHALL equal (L == lat_q) AND (cnt == L); with L=0 and no pending change FILLED SHALL be 1.
REQ-021 A latency change with simultaneous CE=1 SHALL load cnt=0; the data shift still occurs.
REQ-022 RST SHALL take priority over CE and over latency-change detection.

Reset
REQ-023 On a RST=1 edge all stages S1..S_MAX_DEPTH SHALL clear to 0, cnt SHALL clear to 0, lat_q SHALL load L.
REQ-024 After reset Q SHALL read 0 for L>0, and D for L=0.
REQ-025 After reset FILLED SHALL be 0 for L>0 until L CE-qualified edges occur, 1 for L=0.
REQ-026 Reset mid-stream SHALL discard all in-flight data; no pre-reset value appears on Q.

Configuration
REQ-027 Macro PIPE_VALID_EN: when defined, a 1-bit valid chain SHALL shift in parallel with the data chain under the same CE, RST and tap rules; VLD_OUT SHALL be VLD_IN for L=0, else valid stage k.
REQ-028 Valid stages SHALL reset to 0; with L=0, VLD_OUT follows VLD_IN combinationally, also during reset.
REQ-029 Without PIPE_VALID_EN, VLD_IN/VLD_OUT and the valid chain SHALL be absent; data behaviour unchanged.

Verification
REQ-030 WIDTH=18, MAX_DEPTH=4, L=3, CE=1, D=1,2,3,4,5 on successive edges -> Q=0,0,0 then 1,2 on edges 3,4 (Q=D from 3 edges earlier); FILLED rises after edge 3.
REQ-031 L=2, feed 0x0AA,0x155, hold CE=0 for 5 cycles -> Q and FILLED frozen; CE=1 resumes with no lost or duplicated sample.
REQ-032 L=0, D=0x3FFFF -> Q=0x3FFFF in same cycle, FILLED=1; then LAT_SEL=7 (MAX_DEPTH=4) -> Q=S4, FILLED=0 that cycle, 1 after 4 CE edges.
REQ-033 L=4 filled, change LAT_SEL to 1 with CE=1 same cycle -> FILLED=0 that cycle, cnt=0; FILLED=1 after next CE edge; Q=S1 immediately.
REQ-034 Stream D=10..20 at L=4, assert RST for one edge with CE=1 -> all stages 0, Q=0, FILLED=0; first post-reset D appears on Q after 4 edges.
REQ-035 PIPE_VALID_EN defined, L=2, VLD_IN pulse 1 on one edge with D=0x123 -> VLD_OUT=1 exactly when Q=0x123, 0 otherwise; RST clears VLD_OUT.

Source files
------------

// File: rtl/pipe_reg_chain_if.sv
// Bus bundle for pipe_reg_chain: clock enable, latency select, data and status.
// vld_in/vld_out are present only when PIPE_VALID_EN is defined.
interface pipe_reg_chain_if #(
  parameter int WIDTH     = 18,
  parameter int MAX_DEPTH = 4
);
  localparam int LSW = $clog2(MAX_DEPTH + 1);

  logic             ce;
  logic [LSW-1:0]   lat_sel;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             filled;
`ifdef PIPE_VALID_EN
  logic             vld_in;
  logic             vld_out;
`endif

  modport master (
    output ce, lat_sel, d,
`ifdef PIPE_VALID_EN
    output vld_in, input vld_out,
`endif
    input  q, filled
  );

  modport slave (
    input  ce, lat_sel, d,
`ifdef PIPE_VALID_EN
    input  vld_in, output vld_out,
`endif
    output q, filled
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Runtime-selectable 0..MAX_DEPTH register pipe with fill tracking; CE stalls every stage.
// Optional valid-tag chain in parallel when PIPE_VALID_EN is defined.
module pipe_reg_chain #(
  parameter int WIDTH     = 18,
  parameter int MAX_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  pipe_reg_chain_if.slave bus
);
  localparam int             LSW  = $clog2(MAX_DEPTH + 1);
  localparam logic [LSW-1:0] MAXD = LSW'(MAX_DEPTH);

  logic [LSW-1:0]   lat_eff;
  logic [LSW-1:0]   lat_q;
  logic [LSW-1:0]   cnt;
  logic [WIDTH-1:0] stg [MAX_DEPTH];
  logic [WIDTH-1:0] q_mux;

  assign lat_eff = (bus.lat_sel > MAXD) ? MAXD : bus.lat_sel;

  // lat_q tracks the applied latency on every edge, reset and stalls included.
  always_ff @(posedge clk) begin
    lat_q <= lat_eff;
    if (rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stg[i] <= '0;
      end
      cnt <= '0;
    end else begin
      if (bus.ce) begin
        stg[0] <= bus.d;
        for (int i = 1; i < MAX_DEPTH; i++) begin
          stg[i] <= stg[i-1];
        end
      end
      if (lat_eff != lat_q) begin
        cnt <= '0;
      end else if (bus.ce && (cnt < lat_eff)) begin
        cnt <= cnt + LSW'(1);
      end
    end
  end

  always_comb begin
    q_mux = bus.d;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (lat_eff == LSW'(k)) begin
        q_mux = stg[k-1];
      end
    end
  end

  assign bus.q      = q_mux;
  assign bus.filled = (lat_eff == lat_q) && (cnt == lat_eff);

`ifdef PIPE_VALID_EN
  logic vstg [MAX_DEPTH];
  logic v_mux;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        vstg[i] <= 1'b0;
      end
    end else if (bus.ce) begin
      vstg[0] <= bus.vld_in;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        vstg[i] <= vstg[i-1];
      end
    end
  end

  always_comb begin
    v_mux = bus.vld_in;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (lat_eff == LSW'(k)) begin
        v_mux = vstg[k-1];
      end
    end
  end

  assign bus.vld_out = v_mux;
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: directed scenarios then randomized traffic vs a history-queue model.
module tb_pipe_reg_chain;
  localparam int W    = 18;
  localparam int MAXD = 4;
  localparam int LSW  = $clog2(MAXD + 1);

  typedef struct {
    logic [W-1:0] q;
    logic         filled;
    logic         v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_reg_chain_if #(.WIDTH(W), .MAX_DEPTH(MAXD)) bus ();

  pipe_reg_chain #(.WIDTH(W), .MAX_DEPTH(MAXD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t sb [$];

  // Model: the last MAXD accepted samples, newest first, plus edges since latency settled.
  logic [W-1:0] hist  [$];
  bit           vhist [$];
  int           prev_l;
  int           acc;
  bit           armed = 0;

  task automatic model_reset();
    hist.delete();
    vhist.delete();
    for (int i = 0; i < MAXD; i++) begin
      hist.push_back('0);
      vhist.push_back(1'b0);
    end
    acc = 0;
  endtask

  task automatic step(input bit r, input bit c, input int lat, input logic [W-1:0] dv, input bit vi);
    int   l;
    exp_t e;
    rst         = r;
    bus.ce      = c;
    bus.lat_sel = LSW'(lat);
    bus.d       = dv;
`ifdef PIPE_VALID_EN
    bus.vld_in  = vi;
`endif
    l = (lat > MAXD) ? MAXD : lat;
    if (armed) begin
      e.q      = (l == 0) ? dv : hist[l-1];
      e.v      = (l == 0) ? vi : vhist[l-1];
      e.filled = (l == prev_l) && (acc >= l);
      sb.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (c) begin
        hist.push_front(dv);
        void'(hist.pop_back());
        vhist.push_front(vi);
        void'(vhist.pop_back());
      end
      if (l != prev_l) acc = 0;
      else if (c) acc++;
    end
    prev_l = l;
    armed  = 1;
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.q !== e.q) begin
          failures++;
          $display("FAIL q: got %h expected %h at %0t", bus.q, e.q, $time);
        end
        checks++;
        if (bus.filled !== e.filled) begin
          failures++;
          $display("FAIL filled: got %b expected %b at %0t", bus.filled, e.filled, $time);
        end
`ifdef PIPE_VALID_EN
        checks++;
        if (bus.vld_out !== e.v) begin
          failures++;
          $display("FAIL vld_out: got %b expected %b at %0t", bus.vld_out, e.v, $time);
        end
`endif
      end
    end
  end

  initial begin : stim
    int lat;
    int waited;
    bus.ce      = 1'b0;
    bus.lat_sel = '0;
    bus.d       = '0;
`ifdef PIPE_VALID_EN
    bus.vld_in  = 1'b0;
`endif
    rst = 1'b1;
    #1;

    // L=3 fill from reset: D=1..5 reappears three edges later.
    step(1, 0, 3, '0, 0);
    step(0, 0, 3, '0, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, 3, W'(i), 0);

    // L=2 stall: outputs freeze for five CE=0 cycles, then resume.
    step(0, 1, 2, 18'h000AA, 0);
    step(0, 1, 2, 18'h00155, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 2, W'($urandom), 0);
    for (int i = 0; i < 4; i++) step(0, 1, 2, W'(i + 40), 0);

    // Bypass, then out-of-range select clamps to full depth.
    step(0, 1, 0, 18'h3FFFF, 1);
    step(0, 1, 0, 18'h3FFFF, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 7, W'(i + 100), 0);

    // Filled at L=4, then drop to L=1 with CE high.
    for (int i = 0; i < 6; i++) step(0, 1, 4, W'(i + 200), 0);
    step(0, 1, 1, W'(300), 0);
    step(0, 1, 1, W'(301), 0);
    step(0, 1, 1, W'(302), 0);

    // Mid-stream reset at L=4 discards in-flight data.
    for (int i = 10; i <= 15; i++) step(0, 1, 4, W'(i), 0);
    step(1, 1, 4, W'(16), 0);
    for (int i = 17; i <= 22; i++) step(0, 1, 4, W'(i), 0);

    // Reset while bypassed: Q and valid follow the inputs.
    step(1, 1, 0, 18'h00155, 1);
    step(1, 0, 0, 18'h002AA, 0);

    // Single valid pulse at L=2, then reset clears it.
    step(0, 1, 2, '0, 0);
    step(0, 1, 2, 18'h00123, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 2, '0, 0);
    step(0, 1, 2, 18'h00456, 1);
    step(0, 1, 2, '0, 0);
    step(1, 0, 2, '0, 0);
    step(0, 0, 2, '0, 0);

    lat = 3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) lat = $urandom_range(0, 7);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, lat,
           W'($urandom), bit'($urandom_range(0, 1)));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
